// File: rtl/folded_dot_product_engine_if.sv
// Bus bundle for folded_dot_product_engine: command, package stream, result stream and status.
// A transfer happens on a rising edge where valid and ready are both high; a producer holding
// valid must keep its payload stable until that edge, and ready never depends on valid.
interface folded_dot_product_engine_if #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8,
  parameter int ACC_WIDTH     = 80,
  parameter int LEN_WIDTH     = 16
);
  logic                                 start;
  logic [LEN_WIDTH-1:0]                 total;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_input;
  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] second_row_input;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [ACC_WIDTH-1:0]                 dot_product_output;
  logic                                 busy;
  logic [2:0]                           state_dbg;

  modport master (
    output start, total, in_valid, first_row_input, second_row_input, out_ready,
    input  in_ready, out_valid, dot_product_output, busy, state_dbg
  );

  modport slave (
    input  start, total, in_valid, first_row_input, second_row_input, out_ready,
    output in_ready, out_valid, dot_product_output, busy, state_dbg
  );
endinterface

// File: rtl/folded_dot_product_engine.sv
// Signed dot product over a stream of NO_OF_UNITS-element packages, folded onto
// NO_OF_UNITS/FOLD multipliers, with a registered adder tree and a wrapping accumulator.
module folded_dot_product_engine #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8,
  parameter int FOLD          = 2,
  parameter int ACC_WIDTH     = 80,
  parameter int LEN_WIDTH     = 16
) (
  input logic                         clk,
  input logic                         reset,
  folded_dot_product_engine_if.slave  bus
);

  localparam int LANES = NO_OF_UNITS / FOLD;
  localparam int SW    = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int PW    = 2 * ELEMENT_WIDTH;
  localparam int VW    = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam logic [SW-1:0] LAST = SW'(FOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FOLD, S_DRAIN, S_DONE} state_t;

  state_t                 state_q;
  logic [SW-1:0]          slice_q;
  logic [LEN_WIDTH-1:0]   rem_q;
  logic [VW-1:0]          a_buf_q, b_buf_q;
  logic                   drain_q;
  logic                   in_ready_q, out_valid_q, busy_q;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, result_q;

  logic signed [ELEMENT_WIDTH-1:0] a_sl [LANES];
  logic signed [ELEMENT_WIDTH-1:0] b_sl [LANES];
  logic signed [PW-1:0]            prod_d [LANES];
  logic signed [PW-1:0]            prod_q [LANES];
  logic                            prod_v_q;
  logic signed [ACC_WIDTH-1:0]     sum_d, sum_q;
  logic                            sum_v_q;

  logic hs;
  assign hs = bus.in_valid & in_ready_q;

  // Lane j of slice s is element s*LANES+j, counted from the MSB end of the package.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      a_sl[j] = '0;
      b_sl[j] = '0;
      for (int s = 0; s < FOLD; s++) begin
        if (slice_q == SW'(s)) begin
          a_sl[j] = a_buf_q[VW-1-(s*LANES+j)*ELEMENT_WIDTH -: ELEMENT_WIDTH];
          b_sl[j] = b_buf_q[VW-1-(s*LANES+j)*ELEMENT_WIDTH -: ELEMENT_WIDTH];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      prod_d[j] = PW'(a_sl[j]) * PW'(b_sl[j]);
    end
    sum_d = '0;
    for (int j = 0; j < LANES; j++) begin
      sum_d = sum_d + ACC_WIDTH'(prod_q[j]);
    end
    acc_d = acc_q;
    if (sum_v_q) begin
      acc_d = acc_q + sum_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < LANES; j++) begin
        prod_q[j] <= '0;
      end
      prod_v_q <= 1'b0;
      sum_q    <= '0;
      sum_v_q  <= 1'b0;
    end else begin
      for (int j = 0; j < LANES; j++) begin
        prod_q[j] <= prod_d[j];
      end
      prod_v_q <= (state_q == S_FOLD);
      sum_q    <= sum_d;
      sum_v_q  <= prod_v_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      slice_q     <= '0;
      rem_q       <= '0;
      a_buf_q     <= '0;
      b_buf_q     <= '0;
      drain_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
    end else begin
      acc_q <= acc_d;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            acc_q  <= '0;
            busy_q <= 1'b1;
            rem_q  <= bus.total;
            if (bus.total != '0) begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_LOAD: begin
          if (hs) begin
            a_buf_q    <= bus.first_row_input;
            b_buf_q    <= bus.second_row_input;
            rem_q      <= rem_q - LEN_WIDTH'(1);
            slice_q    <= '0;
            state_q    <= S_FOLD;
            in_ready_q <= (FOLD == 1) && (rem_q != LEN_WIDTH'(1));
          end
        end
        S_FOLD: begin
          if (slice_q != LAST) begin
            slice_q    <= slice_q + SW'(1);
            in_ready_q <= ((slice_q + SW'(1)) == LAST) && (rem_q != '0);
          end else if (rem_q == '0) begin
            state_q    <= S_DRAIN;
            in_ready_q <= 1'b0;
          end else if (hs) begin
            // Back-to-back package: next slice 0 follows directly for full throughput.
            a_buf_q    <= bus.first_row_input;
            b_buf_q    <= bus.second_row_input;
            rem_q      <= rem_q - LEN_WIDTH'(1);
            slice_q    <= '0;
            in_ready_q <= (FOLD == 1) && (rem_q != LEN_WIDTH'(1));
          end else begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          // Two cycles cover the product and tree stages; acc_d already holds the last slice.
          if (drain_q) begin
            drain_q     <= 1'b0;
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= acc_d;
          end else begin
            drain_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.out_valid          = out_valid_q;
  assign bus.dot_product_output = result_q;
  assign bus.busy               = busy_q;
  assign bus.state_dbg          = state_q;

endmodule

// File: tb/tb_folded_dot_product_engine.sv
// Bench for folded_dot_product_engine: FOLD=2 main instance plus FOLD=1 and FOLD=8 instances.
module tb_folded_dot_product_engine;
  localparam int EW  = 32;
  localparam int N   = 8;
  localparam int ACC = 80;
  localparam int LEN = 16;
  localparam int VW  = EW * N;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  folded_dot_product_engine_if #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .ACC_WIDTH(ACC), .LEN_WIDTH(LEN)) bus ();
  folded_dot_product_engine_if #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .ACC_WIDTH(ACC), .LEN_WIDTH(LEN)) bus1 ();
  folded_dot_product_engine_if #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .ACC_WIDTH(ACC), .LEN_WIDTH(LEN)) bus8 ();

  folded_dot_product_engine #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .FOLD(2), .ACC_WIDTH(ACC), .LEN_WIDTH(LEN))
    u_dut (.clk(clk), .reset(reset), .bus(bus));
  folded_dot_product_engine #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .FOLD(1), .ACC_WIDTH(ACC), .LEN_WIDTH(LEN))
    u_dut_f1 (.clk(clk), .reset(reset), .bus(bus1));
  folded_dot_product_engine #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .FOLD(8), .ACC_WIDTH(ACC), .LEN_WIDTH(LEN))
    u_dut_f8 (.clk(clk), .reset(reset), .bus(bus8));

  logic [ACC-1:0] exp_q[$];
  int             lat_q[$];
  logic [ACC-1:0] exp1_q[$];
  logic [ACC-1:0] exp8_q[$];
  int             hs_q[$];
  int             last_evt = 0;
  int             hs1 = 0;
  int             hs8 = 0;
  logic           ov_prev = 1'b0;

  task automatic check_val(input string name, input logic [ACC-1:0] got, input logic [ACC-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(got), $signed(exp), cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [VW-1:0] mk_ramp(input int base, input int step);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[VW-1-i*EW -: EW] = EW'(base + i * step);
    return v;
  endfunction

  function automatic logic [VW-1:0] mk_const(input int val);
    return mk_ramp(val, 0);
  endfunction

  task automatic expect_result(input logic [ACC-1:0] v, input int lat);
    exp_q.push_back(v);
    lat_q.push_back(lat);
  endtask

  task automatic start_run(input int tot);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.total = LEN'(tot);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_pkg(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic ok;
    ok = 1'b0;
    bus.first_row_input  = a;
    bus.second_row_input = b;
    bus.in_valid         = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    check_bit("pkg_accepted", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && (exp1_q.size() == 0) && (exp8_q.size() == 0)
           && !bus.busy && !bus1.busy && !bus8.busy;
    end
    check_bit("run_complete", ok, 1'b1);
    if (!ok) begin
      exp_q.delete(); lat_q.delete(); exp1_q.delete(); exp8_q.delete();
    end
  endtask

  // Main scoreboard: latency on the rising out_valid, value on every valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        last_evt = cyc;
        hs_q.push_back(cyc);
      end
      if (bus.start && !bus.busy) last_evt = cyc;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check_bit("unexpected_out_valid", bus.out_valid, 1'b0);
        end else begin
          if (!ov_prev) check_int("out_latency", cyc - last_evt, lat_q[0]);
          check_val("result", bus.dot_product_output, exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (bus1.in_valid && bus1.in_ready) hs1 = cyc;
      if (bus8.in_valid && bus8.in_ready) hs8 = cyc;
      if (bus1.out_valid) begin
        if (exp1_q.size() == 0) check_bit("f1_unexpected_out", bus1.out_valid, 1'b0);
        else begin
          check_val("f1_result", bus1.dot_product_output, exp1_q.pop_front());
          check_int("f1_latency", cyc - hs1, 4);
        end
      end
      if (bus8.out_valid) begin
        if (exp8_q.size() == 0) check_bit("f8_unexpected_out", bus8.out_valid, 1'b0);
        else begin
          check_val("f8_result", bus8.dot_product_output, exp8_q.pop_front());
          check_int("f8_latency", cyc - hs8, 11);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;  bus.total = '0;  bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
    bus.first_row_input = '0;  bus.second_row_input = '0;
    bus1.start = 1'b0; bus1.total = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    bus1.first_row_input = '0; bus1.second_row_input = '0;
    bus8.start = 1'b0; bus8.total = '0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    bus8.first_row_input = '0; bus8.second_row_input = '0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_in_ready", bus.in_ready, 1'b0);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_val("rst_result", bus.dot_product_output, '0);
    check_int("rst_state", int'(bus.state_dbg), 0);
    reset = 1'b1;

    // Single package, ramp times 2: 2*(1+..+8) = 72.
    expect_result(ACC'(72), 5);
    start_run(1);
    send_pkg(mk_ramp(1, 1), mk_const(2));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_bit("t1_in_ready_low", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    wait_done();

    // Four sustained packages of ones: 32, accepted every second cycle.
    hs_q.delete();
    expect_result(ACC'(32), 5);
    start_run(4);
    for (int p = 0; p < 4; p++) send_pkg(mk_const(1), mk_const(1));
    bus.in_valid = 1'b0;
    wait_done();
    check_int("t2_hs_count", hs_q.size(), 4);
    if (hs_q.size() == 4)
      for (int i = 0; i < 3; i++) check_int("t2_hs_spacing", hs_q[i+1] - hs_q[i], 2);

    // Signed on all three folds: 2 * 8 * (-3*5) = -240.
    expect_result(ACC'(-240), 5);
    exp1_q.push_back(ACC'(-240));
    exp8_q.push_back(ACC'(-240));
    @(posedge clk); #1;
    bus.start = 1'b1;  bus.total = LEN'(2);
    bus1.start = 1'b1; bus1.total = LEN'(2);
    bus8.start = 1'b1; bus8.total = LEN'(2);
    bus.first_row_input = mk_const(-3);  bus.second_row_input = mk_const(5);  bus.in_valid = 1'b1;
    bus1.first_row_input = mk_const(-3); bus1.second_row_input = mk_const(5); bus1.in_valid = 1'b1;
    bus8.first_row_input = mk_const(-3); bus8.second_row_input = mk_const(5); bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus1.start = 1'b0; bus8.start = 1'b0;
    wait_done();
    bus.in_valid = 1'b0; bus1.in_valid = 1'b0; bus8.in_valid = 1'b0;

    // Empty run; starts during DRAIN and DONE are ignored.
    expect_result(ACC'(0), 3);
    start_run(0);
    bus.start = 1'b1; bus.total = LEN'(5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_bit("t0_valid_held", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_bit("t0_idle_busy", bus.busy, 1'b0);
    check_bit("t0_no_in_ready", bus.in_ready, 1'b0);
    wait_done();

    // Most negative elements: 8 * 2^62 = 2^65, beyond 64 bits.
    expect_result(80'h2_0000_0000_0000_0000, 5);
    start_run(1);
    send_pkg(mk_const(int'(32'h8000_0000)), mk_const(int'(32'h8000_0000)));
    bus.in_valid = 1'b0;
    wait_done();

    // Output backpressure: sum of squares 1..8 = 204 held for 10 cycles.
    expect_result(ACC'(204), 5);
    bus.out_ready = 1'b0;
    start_run(1);
    send_pkg(mk_ramp(1, 1), mk_ramp(1, 1));
    bus.in_valid = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge clk);
        seen = bus.out_valid;
      end
      check_bit("bp_out_valid_seen", seen, 1'b1);
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      check_bit("bp_hold_valid", bus.out_valid, 1'b1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_bit("bp_busy_dropped", bus.busy, 1'b0);
    check_bit("bp_valid_dropped", bus.out_valid, 1'b0);
    wait_done();

    // Input gaps of 3 cycles: 36 - 64 + 120 = 92.
    expect_result(ACC'(92), 5);
    start_run(3);
    send_pkg(mk_ramp(1, 1), mk_const(1));
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_pkg(mk_const(2), mk_const(-4));
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_pkg(mk_ramp(1, 1), mk_ramp(8, -1));
    bus.in_valid = 1'b0;
    wait_done();

    // Abort mid-FOLD with an asynchronous reset, then a clean run.
    start_run(4);
    send_pkg(mk_const(1), mk_const(1));
    #2;
    reset = 1'b0;
    #1;
    check_bit("abort_out_valid", bus.out_valid, 1'b0);
    check_bit("abort_in_ready", bus.in_ready, 1'b0);
    check_bit("abort_busy", bus.busy, 1'b0);
    check_val("abort_result", bus.dot_product_output, '0);
    check_int("abort_state", int'(bus.state_dbg), 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    expect_result(ACC'(8), 5);
    start_run(1);
    send_pkg(mk_const(1), mk_const(1));
    bus.in_valid = 1'b0;
    wait_done();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/folded_dot_product_engine.md
Name: folded_dot_product_engine

Overview:
- Parametrised successor of the eight-lane dot-product-with-control unit.
- Computes the signed integer dot product of two vectors delivered as a stream of NO_OF_UNITS-element packages.
- Time-multiplexes NO_OF_UNITS/FOLD multipliers over FOLD cycles per package, reduces each slice through a registered adder tree, and accumulates across packages.
- Sits between the row/vector fetch logic and the CG scalar update path. Uses valid/ready handshakes on both input and output instead of fixed outsider delay chains.

Parameters:
- ELEMENT_WIDTH, 32, width of one signed two's-complement element.
- NO_OF_UNITS, 8, elements per input package. Power of two, ≥2.
- FOLD, 2, cycles per package. Divides NO_OF_UNITS. FOLD=1 is fully parallel; FOLD=NO_OF_UNITS uses a single multiplier.
- ACC_WIDTH, 80, accumulator/result width. Must be ≥ 2*ELEMENT_WIDTH + log2(NO_OF_UNITS).
- LEN_WIDTH, 16, width of the package-count input.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a new dot product. Honoured only in IDLE.
- total  in  LEN_WIDTH  number of packages in this dot product. Sampled when start is honoured.
- in_valid  in  1  package present on the row inputs.
- in_ready  out  1  engine accepts a package this cycle.
- first_row_input  in  ELEMENT_WIDTH*NO_OF_UNITS  vector A package. Element 0 in the MSBs.
- second_row_input  in  ELEMENT_WIDTH*NO_OF_UNITS  vector B package. Same layout as vector A.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- dot_product_output  out  ACC_WIDTH  signed result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE. in_ready, out_valid, busy = 0. dot_product_output, accumulator, package buffer and pipeline registers = 0.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE, LOAD, FOLD, DRAIN, DONE.
- IDLE:
  - start=1 and total≠0: clear accumulator, latch total into the remaining-package counter, go to LOAD.
  - start=1 and total=0: clear accumulator, go to DRAIN.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - Handshake (in_valid & in_ready): both packages are registered into the buffer, counter decrements, go to FOLD with slice index 0.
  - No handshake: stay in LOAD.
- FOLD:
  - Each cycle issues slice s (0..FOLD-1), which is lanes s*NO_OF_UNITS/FOLD .. (s+1)*NO_OF_UNITS/FOLD-1 counted from the MSB end, to the multipliers.
  - On slice FOLD-1:
    - Remaining>0: in_ready=1 this same cycle. Handshake loads the next package and stays in FOLD with s=0, giving one package per FOLD cycles sustained. No handshake: go to LOAD.
    - Remaining=0: in_ready=0, go to DRAIN.
  - In all other FOLD cycles in_ready=0.
- Pipeline:
  - Stage 1: products registered, 2*ELEMENT_WIDTH signed.
  - Stage 2: registered adder tree; sign-extended sum of the slice.
  - Stage 3: accumulator += sign-extended tree sum, modulo 2^ACC_WIDTH (wraps, no saturation).
  - A stage-valid bit travels with each slice; the accumulator adds only valid slices.
- DRAIN:
  - Exactly 2 cycles, then go to DONE.
  - Last slice issued in cycle T gives out_valid=1 from cycle T+3.
  - From the last accepting handshake in cycle A: out_valid at A+FOLD+3.
- DONE:
  - out_valid=1 and dot_product_output=accumulator, both held stable until out_ready=1.
  - On handshake, go to IDLE next cycle and drop out_valid.
  - dot_product_output keeps the last result until the next DONE.
- Simultaneous events: in_valid while in_ready=0 has no effect, and the input must be held by the producer. out_ready outside DONE is ignored.

Test Plan:
- NO_OF_UNITS=8, FOLD=2, start with total=1, A=1..8, B=all 2, in_valid held → handshake in cycle 0; in_ready=0 in cycles 1–5; out_valid rises in cycle 5; dot_product_output=72.
- total=4, in_valid held high, A=all 1, B=all 1 → handshakes in cycles 0,2,4,6 (in_ready high only on slice-1 cycles after the first); out_valid in cycle 11; result=32.
- Signed: total=2, A=all -3, B=all 5; FOLD=1 and FOLD=8 builds → result=-240 in both; out_valid at A+4 and A+11 respectively.
- total=0 → no in_ready, out_valid 3 cycles after start, result=0. start pulsed during DRAIN/DONE → ignored.
- Backpressure: out_ready low for 10 cycles in DONE → out_valid and result stable. Then out_ready=1 for 1 cycle → IDLE, busy=0. in_valid gaps of 3 cycles in LOAD → stalls with correct final sum.
- Assert reset mid-FOLD of a total=4 run → outputs 0 immediately without a clock edge. After release, run total=1 with A=B=all 1 → result=8, unpolluted by the aborted run.
